// File: rtl/ps2_key_injector.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_injector
// Description : Queues scancodes from an autotype/paste source and plays them
//               out as timed press/release events on the 11-bit ps2_key
//               toggle-event bus, merged with the live hps_io keyboard stream.
//               ps2_key_o[10] toggles once per event, [9] is pressed,
//               [8:0] is {ext, code}.
// Ports       : clk_sys    - system clock
//               reset      - synchronous, active-high
//               ps2_key_i  - live keyboard events from hps_io
//               in_valid   - queue entry offered
//               in_ready   - queue not full (registered)
//               in_code    - scancode {ext, code[7:0]}
//               in_shift   - wrap the key in a shift press/release
//               abort      - flush the queue and release any held keys
//               ps2_key_o  - merged event stream to the matrix decoder
//               busy       - queue non-empty or sequence in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_injector #(
    parameter int          AW          = 4,
    parameter logic [23:0] HOLD_CYCLES = 24'd1_000_000,
    parameter logic [23:0] GAP_CYCLES  = 24'd2_000_000,
    parameter logic [8:0]  SHIFT_CODE  = 9'h012
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key_i,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_code,
    input  logic        in_shift,
    input  logic        abort,
    output logic [10:0] ps2_key_o,
    output logic        busy
);

    localparam int C_DEPTH = 1 << AW;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SHIFT_DN = 4'd1,
        S_KEY_DN   = 4'd2,
        S_W_SD     = 4'd3,
        S_W_KD     = 4'd4,
        S_W_KU     = 4'd5,
        S_GAP      = 4'd6,
        S_ABT_KU   = 4'd7,
        S_ABT_SU   = 4'd8
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q,      state_d;
    logic [23:0]   count_q,      count_d;
    logic [8:0]    code_q,       code_d;
    logic          shift_q,      shift_d;
    logic [AW:0]   wr_ptr_q,     wr_ptr_d;
    logic [AW:0]   rd_ptr_q,     rd_ptr_d;
    logic          in_ready_q,   in_ready_d;
    logic          busy_q,       busy_d;
    logic [10:0]   key_q,        key_d;
    logic          live_tog_q,   live_tog_d;
    logic          pend_valid_q, pend_valid_d;
    logic [9:0]    pend_q,       pend_d;
    logic [9:0]    mem_q [C_DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_live;
    logic       w_stall;
    logic [9:0] w_rd_entry;
    logic       w_inj_emit;
    logic       w_inj_pressed;
    logic [8:0] w_inj_code;
    state_t     w_nstate;
    logic [23:0] w_ncount;

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign ps2_key_o = key_q;

    always_comb begin
        // defaults
        state_d      = state_q;
        count_d      = count_q;
        code_d       = code_q;
        shift_d      = shift_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        key_d        = key_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        live_tog_d   = ps2_key_i[10];

        w_empty       = (wr_ptr_q == rd_ptr_q);
        w_push        = in_valid & in_ready_q & ~abort;
        w_pop         = 1'b0;
        w_rd_entry    = mem_q[rd_ptr_q[AW-1:0]];
        w_live        = ps2_key_i[10] ^ live_tog_q;
        w_inj_emit    = 1'b0;
        w_inj_pressed = 1'b0;
        w_inj_code    = code_q;
        w_nstate      = state_q;
        w_ncount      = count_q;
        w_stall       = 1'b0;

        // --------------------------------------------------------------
        // Sequencer. The release/next-press steps are performed on the
        // exit edge of the preceding wait, so successive events are
        // exactly HOLD_CYCLES apart and the cycle after any emission is
        // always a wait cycle.
        // --------------------------------------------------------------
        case (state_q)
            S_IDLE: begin
                if (!w_empty && !abort) begin
                    w_pop    = 1'b1;
                    code_d   = w_rd_entry[8:0];
                    shift_d  = w_rd_entry[9];
                    w_nstate = w_rd_entry[9] ? S_SHIFT_DN : S_KEY_DN;
                end
            end
            S_SHIFT_DN: begin
                w_inj_emit    = 1'b1;
                w_inj_pressed = 1'b1;
                w_inj_code    = SHIFT_CODE;
                w_ncount      = HOLD_CYCLES;
                w_nstate      = S_W_SD;
            end
            S_KEY_DN: begin
                w_inj_emit    = 1'b1;
                w_inj_pressed = 1'b1;
                w_ncount      = HOLD_CYCLES;
                w_nstate      = S_W_KD;
            end
            S_W_SD: begin
                if (count_q == 24'd1) begin
                    w_inj_emit    = 1'b1;
                    w_inj_pressed = 1'b1;
                    w_ncount      = HOLD_CYCLES;
                    w_nstate      = S_W_KD;
                end else begin
                    w_ncount = count_q - 24'd1;
                end
            end
            S_W_KD: begin
                if (count_q == 24'd1) begin
                    w_inj_emit = 1'b1;
                    if (shift_q) begin
                        w_ncount = HOLD_CYCLES;
                        w_nstate = S_W_KU;
                    end else begin
                        w_ncount = GAP_CYCLES;
                        w_nstate = S_GAP;
                    end
                end else begin
                    w_ncount = count_q - 24'd1;
                end
            end
            S_W_KU: begin
                if (count_q == 24'd1) begin
                    w_inj_emit = 1'b1;
                    w_inj_code = SHIFT_CODE;
                    w_ncount   = GAP_CYCLES;
                    w_nstate   = S_GAP;
                end else begin
                    w_ncount = count_q - 24'd1;
                end
            end
            S_GAP: begin
                if (count_q == 24'd1) begin
                    w_ncount = 24'd0;
                    w_nstate = S_IDLE;
                end else begin
                    w_ncount = count_q - 24'd1;
                end
            end
            S_ABT_KU: begin
                w_inj_emit = 1'b1;
                w_nstate   = shift_q ? S_ABT_SU : S_IDLE;
            end
            S_ABT_SU: begin
                w_inj_emit = 1'b1;
                w_inj_code = SHIFT_CODE;
                w_nstate   = S_IDLE;
            end
            default: begin
                w_ncount = 24'd0;
                w_nstate = S_IDLE;
            end
        endcase

        // Abort: release whatever is physically held, key before shift.
        // The releases themselves go out from the ABT states so the abort
        // cycle never emits. IDLE/GAP/ABT states carry on unchanged.
        if (abort) begin
            case (state_q)
                S_W_KD: begin
                    w_inj_emit = 1'b0;
                    w_ncount   = 24'd0;
                    w_nstate   = S_ABT_KU;
                end
                S_W_SD, S_W_KU: begin
                    w_inj_emit = 1'b0;
                    w_ncount   = 24'd0;
                    w_nstate   = S_ABT_SU;
                end
                S_SHIFT_DN, S_KEY_DN: begin
                    w_inj_emit = 1'b0;
                    w_ncount   = 24'd0;
                    w_nstate   = S_IDLE;
                end
                default: ;
            endcase
        end

        // A pending live event owns this cycle's output slot; an injector
        // emission that wants the same slot waits one cycle in place.
        if (w_inj_emit && pend_valid_q) begin
            w_stall    = 1'b1;
            w_inj_emit = 1'b0;
        end

        if (!w_stall) begin
            state_d = w_nstate;
            count_d = w_ncount;
        end

        // --------------------------------------------------------------
        // Output merge: pending live > injector > new live event.
        // A live event that cannot go out now lands in the pending slot.
        // --------------------------------------------------------------
        if (pend_valid_q) begin
            key_d        = {~key_q[10], pend_q};
            pend_valid_d = w_live;
            pend_d       = ps2_key_i[9:0];
        end else if (w_inj_emit) begin
            key_d = {~key_q[10], w_inj_pressed, w_inj_code};
            if (w_live) begin
                pend_valid_d = 1'b1;
                pend_d       = ps2_key_i[9:0];
            end
        end else if (w_live) begin
            key_d = {~key_q[10], ps2_key_i[9:0]};
        end

        // --------------------------------------------------------------
        // FIFO pointers; abort flushes by catching the read pointer up.
        // --------------------------------------------------------------
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, w_push};
        if (abort) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, w_pop};
        end

        // Ready reflects occupancy after this cycle's push/pop.
        in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));

        busy_d = (count_q != 24'd0) || (state_q != S_IDLE) || !w_empty;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= 24'd0;
            code_q       <= 9'd0;
            shift_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            key_q        <= 11'd0;
            live_tog_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_q       <= 10'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            code_q       <= code_d;
            shift_q      <= shift_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            key_q        <= key_d;
            live_tog_q   <= live_tog_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end

    // Queue storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_shift, in_code};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_injector
// Description : Directed bench for ps2_key_injector (AW=2, HOLD=4, GAP=8).
//               Expected events are computed from a bench-side toggle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_injector;

    logic        clk_sys;
    logic        reset;
    logic [10:0] ps2_key_i;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_code;
    logic        in_shift;
    logic        abort;
    logic [10:0] ps2_key_o;
    logic        busy;

    int   n_checks;
    int   n_errors;
    logic tog;

    ps2_key_injector #(
        .AW          (2),
        .HOLD_CYCLES (24'd4),
        .GAP_CYCLES  (24'd8),
        .SHIFT_CODE  (9'h012)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key_i (ps2_key_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_shift  (in_shift),
        .abort     (abort),
        .ps2_key_o (ps2_key_o),
        .busy      (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next expected event word; advances the modelled toggle bit.
    function automatic logic [10:0] ev(input logic p, input logic [8:0] c);
        tog = ~tog;
        return {tog, p, c};
    endfunction

    task automatic wait_evt(input string tag, input logic p, input logic [8:0] c);
        logic       seen;
        logic [10:0] e;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (ps2_key_o[10] !== tog) seen = 1'b1;
        end
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        e = ev(p, c);
        chk(tag, {21'd0, ps2_key_o}, {21'd0, e});
    endtask

    task automatic no_evt(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ps2_key_o[10] !== tog) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    task automatic push1(input logic [8:0] c, input logic s);
        in_valid = 1'b1;
        in_code  = c;
        in_shift = s;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] burst [5];
        n_checks  = 0;
        n_errors  = 0;
        tog       = 1'b0;
        reset     = 1'b1;
        ps2_key_i = 11'd0;
        in_valid  = 1'b0;
        in_code   = 9'd0;
        in_shift  = 1'b0;
        abort     = 1'b0;

        // ---------------- reset state
        ticks(3);
        chk("rst_key",   {21'd0, ps2_key_o}, 32'h0);
        chk("rst_ready", {31'd0, in_ready},  32'd1);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        reset = 1'b0;
        tick();

        // ---------------- single entry, no shift
        push1(9'h01C, 1'b0);                 // edge N
        tick();                              // N+1 pop
        chk("s1_busy_n1", {31'd0, busy}, 32'd1);
        tick();                              // N+2
        chk("s1_press", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h01C)});
        ticks(3);                            // N+5
        chk("s1_hold", {21'd0, ps2_key_o}, 32'h61C);
        tick();                              // N+6
        chk("s1_release", {21'd0, ps2_key_o}, {21'd0, ev(1'b0, 9'h01C)});
        ticks(8);                            // N+14
        chk("s1_busy_n14", {31'd0, busy}, 32'd1);
        tick();                              // N+15
        chk("s1_busy_n15", {31'd0, busy}, 32'd0);

        // ---------------- shifted entry
        push1(9'h016, 1'b1);                 // M
        ticks(2);                            // M+2
        chk("sh_shift_dn", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h012)});
        ticks(3);
        chk("sh_gap_m5", {21'd0, ps2_key_o}, 32'h612);
        tick();                              // M+6
        chk("sh_key_dn", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h016)});
        ticks(4);                            // M+10
        chk("sh_key_up", {21'd0, ps2_key_o}, {21'd0, ev(1'b0, 9'h016)});
        ticks(4);                            // M+14
        chk("sh_shift_up", {21'd0, ps2_key_o}, {21'd0, ev(1'b0, 9'h012)});
        ticks(8);                            // M+22
        chk("sh_busy_m22", {31'd0, busy}, 32'd1);
        tick();
        chk("sh_busy_m23", {31'd0, busy}, 32'd0);

        // ---------------- collision with a live event
        push1(9'h05A, 1'b0);                 // P
        tick();                              // P+1
        ps2_key_i = {1'b1, 1'b1, 9'h029};
        tick();                              // P+2
        chk("col_inj_first", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h05A)});
        tick();                              // P+3
        chk("col_live_next", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h029)});
        ticks(3);                            // P+6
        chk("col_release", {21'd0, ps2_key_o}, {21'd0, ev(1'b0, 9'h05A)});
        ticks(10);                           // idle again
        ps2_key_i = {1'b0, 1'b0, 9'h029};
        tick();
        chk("pass_live", {21'd0, ps2_key_o}, {21'd0, ev(1'b0, 9'h029)});
        no_evt("pass_quiet", 4);

        // ---------------- FIFO full (depth 4)
        burst[0] = 9'h01D; burst[1] = 9'h024; burst[2] = 9'h02D;
        burst[3] = 9'h035; burst[4] = 9'h03C;
        push1(9'h015, 1'b0);                 // Q
        ticks(2);                            // Q+2
        chk("ff_a_press", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h015)});
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_code  = burst[k];
            in_shift = 1'b0;
            tick();
            if (k == 2) chk("ff_ready_3", {31'd0, in_ready}, 32'd1);
            if (k == 3) chk("ff_ready_4", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        wait_evt("ff_a_rel", 1'b0, 9'h015);
        for (int k = 0; k < 4; k++) begin
            wait_evt("ff_press", 1'b1, burst[k]);
            wait_evt("ff_rel",   1'b0, burst[k]);
        end
        no_evt("ff_fifth_dropped", 40);
        chk("ff_busy_end", {31'd0, busy}, 32'd0);

        // ---------------- abort in W_KD of a shifted key, 3 queued
        push1(9'h016, 1'b1);                 // R
        tick();                              // R+1
        tick();                              // R+2
        chk("ab_shift_dn", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h012)});
        push1(9'h01B, 1'b0);                 // R+3
        push1(9'h023, 1'b0);                 // R+4
        push1(9'h02B, 1'b1);                 // R+5
        tick();                              // R+6
        chk("ab_key_dn", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h016)});
        tick();                              // R+7
        abort = 1'b1;
        tick();                              // R+8
        abort = 1'b0;
        chk("ab_ready", {31'd0, in_ready}, 32'd1);
        tick();                              // R+9
        chk("ab_key_rel", {21'd0, ps2_key_o}, {21'd0, ev(1'b0, 9'h016)});
        tick();                              // R+10
        chk("ab_shift_rel", {21'd0, ps2_key_o}, {21'd0, ev(1'b0, 9'h012)});
        tick();                              // R+11
        chk("ab_busy", {31'd0, busy}, 32'd0);
        no_evt("ab_quiet", 40);

        // ---------------- reset mid-sequence
        push1(9'h033, 1'b0);                 // S
        ticks(2);                            // S+2
        chk("rs_press", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h033)});
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tog   = 1'b0;
        chk("rs_key",   {21'd0, ps2_key_o}, 32'h0);
        chk("rs_ready", {31'd0, in_ready},  32'd1);
        chk("rs_busy",  {31'd0, busy},      32'd0);
        push1(9'h01C, 1'b0);                 // T
        ticks(2);
        chk("rs2_press", {21'd0, ps2_key_o}, {21'd0, ev(1'b1, 9'h01C)});
        ticks(4);
        chk("rs2_release", {21'd0, ps2_key_o}, {21'd0, ev(1'b0, 9'h01C)});
        ticks(9);
        chk("rs2_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
